// File: rtl/instruction_field_decoder_pkg.sv
// Shared opcode constants, format codes and the decoded-field record for the
// RV32 L/S/R instruction field decoder.
package instruction_field_decoder_pkg;

    localparam int INSTR_W = 32;
    localparam int IMM_W   = 12;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    typedef enum logic [1:0] {
        FMT_UNKNOWN = 2'b00,
        FMT_L       = 2'b01,
        FMT_S       = 2'b10,
        FMT_R       = 2'b11
    } fmt_e;

    // Every field of every supported format, extracted side by side.
    typedef struct packed {
        fmt_e        fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [11:0] l_imm;
        logic [4:0]  l_rd;
        logic [6:0]  s_imm_hi;
        logic [4:0]  s_rs2;
        logic [4:0]  s_imm_lo;
        logic [11:0] s_imm;
        logic [6:0]  r_funct7;
        logic [4:0]  r_rs2;
        logic [4:0]  r_rd;
    } fields_t;

    function automatic fmt_e classify(input logic [6:0] opc);
        fmt_e f;
        case (opc)
            OPC_LOAD:  f = FMT_L;
            OPC_STORE: f = FMT_S;
            OPC_OP:    f = FMT_R;
            default:   f = FMT_UNKNOWN;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instruction_field_decoder_split.sv
// Purely combinational slicing of one 32-bit instruction into the L, S and R
// field sets, plus opcode-based format classification.
module instr_field_split
    import instruction_field_decoder_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] i_instr,
    output fields_t         o_fields
);

    logic [6:0] w_opcode;

    assign w_opcode = i_instr[6:0];

    always_comb begin
        o_fields          = '0;
        o_fields.fmt      = classify(w_opcode);
        o_fields.opcode   = w_opcode;
        o_fields.funct3   = i_instr[14:12];
        o_fields.rs1      = i_instr[19:15];
        o_fields.l_imm    = i_instr[31:20];
        o_fields.l_rd     = i_instr[11:7];
        o_fields.s_imm_hi = i_instr[31:25];
        o_fields.s_rs2    = i_instr[24:20];
        o_fields.s_imm_lo = i_instr[11:7];
        o_fields.s_imm    = {i_instr[31:25], i_instr[11:7]};
        o_fields.r_funct7 = i_instr[31:25];
        o_fields.r_rs2    = i_instr[24:20];
        o_fields.r_rd     = i_instr[11:7];
    end

endmodule

// File: rtl/instruction_field_decoder.sv
// Registered RV32 L/S/R field decoder: one instruction per cycle, outputs valid
// one edge after presentation, fields hold while no new instruction arrives.
module instruction_field_decoder
    import instruction_field_decoder_pkg::*;
#(
    parameter int SIZE     = 32,
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [SIZE-1:0]     instruction,
    output logic                out_valid,
    output logic [1:0]          fmt,
    output logic [6:0]          opcode,
    output logic [2:0]          funct3,
    output logic [4:0]          rs1,
    output logic [11:0]         l_imm,
    output logic [4:0]          l_rd,
    output logic [6:0]          s_imm_hi,
    output logic [4:0]          s_rs2,
    output logic [4:0]          s_imm_lo,
    output logic [11:0]         s_imm,
    output logic [6:0]          r_funct7,
    output logic [4:0]          r_rs2,
    output logic [4:0]          r_rd,
    output logic [WORDSIZE-1:0] imm_sext
);

    localparam int PAD_W = WORDSIZE - IMM_W;

    fields_t             w_fields;
    logic [IMM_W-1:0]    w_imm_sel;
    logic [WORDSIZE-1:0] w_imm_sext;

    fields_t             r_fields;
    logic [WORDSIZE-1:0] r_imm_sext;
    logic                r_valid;

    instr_field_split #(
        .SIZE(SIZE)
    ) u_split (
        .i_instr (instruction),
        .o_fields(w_fields)
    );

    // R-type and unrecognised opcodes carry no immediate.
    always_comb begin
        w_imm_sel = '0;
        case (w_fields.fmt)
            FMT_L:   w_imm_sel = w_fields.l_imm;
            FMT_S:   w_imm_sel = w_fields.s_imm;
            default: w_imm_sel = '0;
        endcase
        w_imm_sext = {{PAD_W{w_imm_sel[IMM_W-1]}}, w_imm_sel};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_fields   <= '0;
            r_imm_sext <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_fields   <= w_fields;
                r_imm_sext <= w_imm_sext;
            end
        end
    end

    assign out_valid = r_valid;
    assign fmt       = r_fields.fmt;
    assign opcode    = r_fields.opcode;
    assign funct3    = r_fields.funct3;
    assign rs1       = r_fields.rs1;
    assign l_imm     = r_fields.l_imm;
    assign l_rd      = r_fields.l_rd;
    assign s_imm_hi  = r_fields.s_imm_hi;
    assign s_rs2     = r_fields.s_rs2;
    assign s_imm_lo  = r_fields.s_imm_lo;
    assign s_imm     = r_fields.s_imm;
    assign r_funct7  = r_fields.r_funct7;
    assign r_rs2     = r_fields.r_rs2;
    assign r_rd      = r_fields.r_rd;
    assign imm_sext  = r_imm_sext;

endmodule

// File: tb/tb_instruction_field_decoder.sv
// Bench for instruction_field_decoder: directed table, reset/stream sequences
// and randomized traffic against an arithmetic reference model.
module tb_instruction_field_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_valid;
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [11:0] l_imm;
    logic [4:0]  l_rd;
    logic [6:0]  s_imm_hi;
    logic [4:0]  s_rs2;
    logic [4:0]  s_imm_lo;
    logic [11:0] s_imm;
    logic [6:0]  r_funct7;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [63:0] imm_sext;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instruction_field_decoder #(.SIZE(32), .WORDSIZE(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
        .out_valid(out_valid), .fmt(fmt), .opcode(opcode), .funct3(funct3),
        .rs1(rs1), .l_imm(l_imm), .l_rd(l_rd), .s_imm_hi(s_imm_hi),
        .s_rs2(s_rs2), .s_imm_lo(s_imm_lo), .s_imm(s_imm), .r_funct7(r_funct7),
        .r_rs2(r_rs2), .r_rd(r_rd), .imm_sext(imm_sext)
    );

    // Reference model state: what the outputs should show after the last edge.
    typedef struct {
        int          valid, fmt, opcode, funct3, rs1, rd, rs2, funct7, l_imm, s_imm;
        logic [63:0] imm;
    } mdl_t;

    mdl_t exp_m;

    function automatic mdl_t decode(input logic [31:0] ins);
        mdl_t m;
        longint unsigned u;
        int sv;
        u        = longint'(ins);
        m.valid  = 1;
        m.opcode = int'(u % 128);
        m.rd     = int'((u / 128) % 32);
        m.funct3 = int'((u / 4096) % 8);
        m.rs1    = int'((u / 32768) % 32);
        m.rs2    = int'((u / 1048576) % 32);
        m.funct7 = int'(u / 33554432);
        m.l_imm  = int'(u / 1048576);
        m.s_imm  = m.funct7 * 32 + m.rd;
        if (m.opcode == 3)       m.fmt = 1;
        else if (m.opcode == 35) m.fmt = 2;
        else if (m.opcode == 51) m.fmt = 3;
        else                     m.fmt = 0;
        sv = (m.fmt == 1) ? m.l_imm : (m.fmt == 2) ? m.s_imm : 0;
        if (sv >= 2048) sv = sv - 4096;
        m.imm = 64'(longint'(sv));
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_m.valid));
        chk({tag, ".fmt"},       64'(fmt),       64'(exp_m.fmt));
        chk({tag, ".opcode"},    64'(opcode),    64'(exp_m.opcode));
        chk({tag, ".funct3"},    64'(funct3),    64'(exp_m.funct3));
        chk({tag, ".rs1"},       64'(rs1),       64'(exp_m.rs1));
        chk({tag, ".l_imm"},     64'(l_imm),     64'(exp_m.l_imm));
        chk({tag, ".l_rd"},      64'(l_rd),      64'(exp_m.rd));
        chk({tag, ".s_imm_hi"},  64'(s_imm_hi),  64'(exp_m.funct7));
        chk({tag, ".s_rs2"},     64'(s_rs2),     64'(exp_m.rs2));
        chk({tag, ".s_imm_lo"},  64'(s_imm_lo),  64'(exp_m.rd));
        chk({tag, ".s_imm"},     64'(s_imm),     64'(exp_m.s_imm));
        chk({tag, ".r_funct7"},  64'(r_funct7),  64'(exp_m.funct7));
        chk({tag, ".r_rs2"},     64'(r_rs2),     64'(exp_m.rs2));
        chk({tag, ".r_rd"},      64'(r_rd),      64'(exp_m.rd));
        chk({tag, ".imm_sext"},  imm_sext,       exp_m.imm);
    endtask

    // One clock: drive, clock, advance model, sample 1 time unit after the edge.
    task automatic cyc(input logic rst, input logic v, input logic [31:0] ins, input string tag);
        reset = rst; in_valid = v; instruction = ins;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_m = '{default: 0, imm: 64'd0};
        end else if (v) begin
            exp_m = decode(ins);
        end else begin
            exp_m.valid = 0;
        end
        check_model(tag);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  fmt;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rs1, rd, rs2;
        logic [6:0]  f7;
        logic [11:0] limm, simm;
        logic [63:0] imm;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [31:0] ins;
        logic [6:0]  opc_pick;
        int          k;

        tbl[0] = '{32'h00812283, 2'b01, 7'h03, 3'd2, 5'd2, 5'd5,  5'd8,  7'h00, 12'h008, 12'h005, 64'd8};
        tbl[1] = '{32'h0061A623, 2'b10, 7'h23, 3'd2, 5'd3, 5'd12, 5'd6,  7'h00, 12'h006, 12'h00C, 64'd12};
        tbl[2] = '{32'h003100B3, 2'b11, 7'h33, 3'd0, 5'd2, 5'd1,  5'd3,  7'h00, 12'h003, 12'h001, 64'd0};
        tbl[3] = '{32'h403100B3, 2'b11, 7'h33, 3'd0, 5'd2, 5'd1,  5'd3,  7'h20, 12'h403, 12'h401, 64'd0};
        tbl[4] = '{32'hFFC12083, 2'b01, 7'h03, 3'd2, 5'd2, 5'd1,  5'h1C, 7'h7F, 12'hFFC, 12'hFE1, 64'hFFFF_FFFF_FFFF_FFFC};
        tbl[5] = '{32'h0000007F, 2'b00, 7'h7F, 3'd0, 5'd0, 5'd0,  5'd0,  7'h00, 12'h000, 12'h000, 64'd0};

        exp_m = '{default: 0, imm: 64'd0};

        // Reset with a live valid instruction: reset must win.
        cyc(1'b1, 1'b1, 32'h00812283, "reset0");
        cyc(1'b1, 1'b0, 32'h0,        "reset1");

        // Directed table, back-to-back.
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, tbl[i].instr, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.valid", i),  64'(out_valid), 64'd1);
            chk($sformatf("tbl%0d.fmt", i),    64'(fmt),       64'(tbl[i].fmt));
            chk($sformatf("tbl%0d.opc", i),    64'(opcode),    64'(tbl[i].opc));
            chk($sformatf("tbl%0d.f3", i),     64'(funct3),    64'(tbl[i].f3));
            chk($sformatf("tbl%0d.rs1", i),    64'(rs1),       64'(tbl[i].rs1));
            chk($sformatf("tbl%0d.rd", i),     64'(r_rd),      64'(tbl[i].rd));
            chk($sformatf("tbl%0d.rs2", i),    64'(s_rs2),     64'(tbl[i].rs2));
            chk($sformatf("tbl%0d.f7", i),     64'(r_funct7),  64'(tbl[i].f7));
            chk($sformatf("tbl%0d.limm", i),   64'(l_imm),     64'(tbl[i].limm));
            chk($sformatf("tbl%0d.simm", i),   64'(s_imm),     64'(tbl[i].simm));
            chk($sformatf("tbl%0d.imm", i),    imm_sext,       tbl[i].imm);
        end

        // Idle cycle: valid drops, fields hold the unknown-opcode decode.
        cyc(1'b0, 1'b0, 32'hFFC12083, "idle");
        chk("idle.valid",  64'(out_valid), 64'd0);
        chk("idle.opcode", 64'(opcode),    64'h7F);

        // Stream, reset during the third instruction, then resume.
        cyc(1'b0, 1'b1, tbl[0].instr, "str0");
        chk("str0.fmt", 64'(fmt), 64'd1);
        cyc(1'b0, 1'b1, tbl[1].instr, "str1");
        chk("str1.imm", imm_sext, 64'd12);
        cyc(1'b1, 1'b1, tbl[2].instr, "str_rst");
        chk("str_rst.valid", 64'(out_valid), 64'd0);
        chk("str_rst.fmt",   64'(fmt),       64'd0);
        chk("str_rst.imm",   imm_sext,       64'd0);
        chk("str_rst.rs1",   64'(rs1),       64'd0);
        cyc(1'b0, 1'b1, tbl[4].instr, "str3");
        chk("str3.valid", 64'(out_valid), 64'd1);
        chk("str3.imm",   imm_sext,       64'hFFFF_FFFF_FFFF_FFFC);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            k = int'($urandom_range(0, 3));
            opc_pick = (k == 0) ? 7'b0000011 : (k == 1) ? 7'b0100011 :
                       (k == 2) ? 7'b0110011 : ins[6:0];
            ins = {ins[31:7], opc_pick};
            cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), ins,
                $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
